// File: rtl/bpu_update_ctrl_pkg.sv
// Shared definitions for the branch-predictor update controller: branch type
// encodings, default queue depth and the update-command record.
package bpu_update_ctrl_pkg;

    localparam int FIFO_DEPTH_DEF = 4;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_COND = 3'd1;
    localparam logic [2:0] BR_JUMP = 3'd2;
    localparam logic [2:0] BR_CALL = 3'd3;
    localparam logic [2:0] BR_RET  = 3'd4;
    localparam logic [2:0] BR_IND  = 3'd5;

    typedef struct packed {
        logic        add_entry;
        logic        delete_entry;
        logic        pre_error;
        logic        pre_right;
        logic        target_error;
        logic        right_orien;
        logic        push_ras;
        logic        pop_ras;
        logic [31:0] pc;
        logic [4:0]  index;
        logic [31:0] target;
    } upd_cmd_t;

    localparam int CMD_W = $bits(upd_cmd_t);

    // right_orien alone is informational; it never makes a command worth sending.
    function automatic logic cmd_has_action(upd_cmd_t c);
        return c.add_entry | c.delete_entry | c.pre_error | c.pre_right |
               c.target_error | c.push_ras | c.pop_ras;
    endfunction

endpackage

// File: rtl/bpu_upd_fifo.sv
// Synchronous command FIFO with wrap-bit pointers; read data is the current head.
module bpu_upd_fifo
    import bpu_update_ctrl_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [CMD_W-1:0] wr_data,
    input  logic             rd_en,
    output logic [CMD_W-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en && !empty)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/bpu_update_ctrl.sv
// Turns resolved branches into predictor update commands, fetch redirects and
// performance counts; commands are queued so a stalled predictor loses nothing.
module bpu_update_ctrl
    import bpu_update_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_target,
    input  logic [2:0]  br_type,
    input  logic        br_taken,
    input  logic        pred_en,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    input  logic [4:0]  pred_index,
    input  logic        flush,
    input  logic        update_stall,
    output logic        operate_en,
    output logic [31:0] operate_pc,
    output logic [4:0]  operate_index,
    output logic        add_entry,
    output logic        delete_entry,
    output logic        pre_error,
    output logic        pre_right,
    output logic        target_error,
    output logic        right_orien,
    output logic        push_ras,
    output logic        pop_ras,
    output logic [31:0] right_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    upd_cmd_t         new_cmd;
    upd_cmd_t         head_cmd;
    upd_cmd_t         out_cmd;
    logic [CMD_W-1:0] fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             take;
    logic             mispredict;
    logic             new_valid;
    logic             emit;
    logic             fifo_wr;
    logic             fifo_rd;

    assign take       = br_valid && br_ready && !flush;
    assign mispredict = (pred_taken != br_taken) ||
                        (br_taken && pred_taken && (pred_target != br_target)) ||
                        ((br_type == BR_NONE) && pred_en && pred_taken);

    // NOTE: every field gets a default before the priority chain so no latch is inferred.
    always_comb begin
        new_cmd             = '0;
        new_cmd.right_orien = br_taken;
        new_cmd.push_ras    = (br_type == BR_CALL);
        new_cmd.pop_ras     = (br_type == BR_RET);
        new_cmd.pc          = br_pc;
        new_cmd.index       = pred_index;
        new_cmd.target      = br_target;
        if ((br_type == BR_NONE) && pred_en)
            new_cmd.delete_entry = 1'b1;
        else if (!pred_en && br_taken)
            new_cmd.add_entry = 1'b1;
        else if (pred_en && br_taken && (pred_target != br_target) && (br_type != BR_RET))
            new_cmd.target_error = 1'b1;
        else if (pred_en) begin
            if (pred_taken != br_taken)
                new_cmd.pre_error = 1'b1;
            else
                new_cmd.pre_right = 1'b1;
        end
    end

    assign new_valid = take && cmd_has_action(new_cmd);
    assign head_cmd  = upd_cmd_t'(fifo_rd_data);

    // An empty queue lets a fresh command go straight to the output register,
    // giving one-cycle latency; otherwise the head leaves and the newcomer queues.
    assign emit      = !update_stall && (!fifo_empty || new_valid);
    assign fifo_rd   = !update_stall && !fifo_empty;
    assign fifo_wr   = new_valid && (!fifo_empty || update_stall);
    assign br_ready  = !fifo_full;

    bpu_upd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (fifo_wr),
        .wr_data (new_cmd),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            operate_en     <= 1'b0;
            out_cmd        <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            branch_cnt     <= '0;
            mispred_cnt    <= '0;
        end else begin
            operate_en <= emit;
            if (emit)
                out_cmd <= fifo_empty ? new_cmd : head_cmd;

            redirect_valid <= take && mispredict;
            if (take && mispredict) begin
                redirect_pc <= br_taken ? br_target : br_pc + 32'd4;
                if (mispred_cnt != '1)
                    mispred_cnt <= mispred_cnt + 32'd1;
            end

            if (take && (br_type != BR_NONE) && (branch_cnt != '1))
                branch_cnt <= branch_cnt + 32'd1;
        end
    end

    assign operate_pc    = out_cmd.pc;
    assign operate_index = out_cmd.index;
    assign right_target  = out_cmd.target;
    assign add_entry     = out_cmd.add_entry;
    assign delete_entry  = out_cmd.delete_entry;
    assign pre_error     = out_cmd.pre_error;
    assign pre_right     = out_cmd.pre_right;
    assign target_error  = out_cmd.target_error;
    assign right_orien   = out_cmd.right_orien;
    assign push_ras      = out_cmd.push_ras;
    assign pop_ras       = out_cmd.pop_ras;

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// Scoreboard bench: the driver computes expected commands, redirects and counts
// from the branch rules; an independent monitor compares every cycle.
module tb_bpu_update_ctrl;

    localparam int DEPTH = 4;

    logic        clk;
    logic        resetn;
    logic        br_valid;
    logic        br_ready;
    logic [31:0] br_pc;
    logic [31:0] br_target;
    logic [2:0]  br_type;
    logic        br_taken;
    logic        pred_en;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [4:0]  pred_index;
    logic        flush;
    logic        update_stall;
    logic        operate_en;
    logic [31:0] operate_pc;
    logic [4:0]  operate_index;
    logic        add_entry;
    logic        delete_entry;
    logic        pre_error;
    logic        pre_right;
    logic        target_error;
    logic        right_orien;
    logic        push_ras;
    logic        pop_ras;
    logic [31:0] right_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    bpu_update_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .br_valid       (br_valid),
        .br_ready       (br_ready),
        .br_pc          (br_pc),
        .br_target      (br_target),
        .br_type        (br_type),
        .br_taken       (br_taken),
        .pred_en        (pred_en),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .pred_index     (pred_index),
        .flush          (flush),
        .update_stall   (update_stall),
        .operate_en     (operate_en),
        .operate_pc     (operate_pc),
        .operate_index  (operate_index),
        .add_entry      (add_entry),
        .delete_entry   (delete_entry),
        .pre_error      (pre_error),
        .pre_right      (pre_right),
        .target_error   (target_error),
        .right_orien    (right_orien),
        .push_ras       (push_ras),
        .pop_ras        (pop_ras),
        .right_target   (right_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit [7:0]  flags;  // add, delete, pre_error, pre_right, target_error, orien, push, pop
        bit [31:0] pc;
        bit [4:0]  idx;
        bit [31:0] tgt;
    } exp_cmd_t;

    exp_cmd_t  exp_q[$];
    int        checks = 0;
    int        errors = 0;
    bit        mon_en = 0;
    bit        rand_stall = 0;
    bit        last_acc = 0;
    bit        exp_op_en = 0;
    bit        exp_redir_now = 0;
    bit [31:0] exp_redir_pc = 0;
    bit [31:0] exp_branch = 0;
    bit [31:0] exp_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules for one resolved branch, written straight from the requirements.
    function automatic exp_cmd_t model_cmd();
        exp_cmd_t c;
        bit add, del, perr, pright, terr;
        add = 0; del = 0; perr = 0; pright = 0; terr = 0;
        if (br_type == 3'd0 && pred_en)                                       del = 1;
        else if (!pred_en && br_taken)                                        add = 1;
        else if (pred_en && br_taken && pred_target != br_target && br_type != 3'd4) terr = 1;
        else if (pred_en) begin
            if (pred_taken != br_taken) perr = 1;
            else                        pright = 1;
        end
        c.flags = {add, del, perr, pright, terr, br_taken, br_type == 3'd3, br_type == 3'd4};
        c.pc    = br_pc;
        c.idx   = pred_index;
        c.tgt   = br_target;
        return c;
    endfunction

    function automatic bit model_mispredict();
        return (pred_taken != br_taken) ||
               (br_taken && pred_taken && pred_target != br_target) ||
               (br_type == 3'd0 && pred_en && pred_taken);
    endfunction

    // Evaluated mid-cycle, with the inputs and br_ready stable for the coming edge.
    task automatic model_step();
        exp_cmd_t c;
        last_acc      = br_valid && br_ready;
        exp_redir_now = 0;
        if (last_acc && !flush) begin
            c = model_cmd();
            if (c.flags[7:3] != 0 || c.flags[1:0] != 0)
                exp_q.push_back(c);
            if (br_type != 3'd0 && exp_branch != 32'hFFFF_FFFF)
                exp_branch++;
            if (model_mispredict()) begin
                exp_redir_now = 1;
                exp_redir_pc  = br_taken ? br_target : br_pc + 32'd4;
                if (exp_mis != 32'hFFFF_FFFF)
                    exp_mis++;
            end
        end
        exp_op_en = (exp_q.size() > 0) && !update_stall;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #2;
        if (rand_stall)
            update_stall = ($urandom_range(0, 3) == 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] tgt, input logic [2:0] ty,
                         input logic tk, input logic pe, input logic pt,
                         input logic [31:0] ptg, input logic [4:0] pidx, input logic fl);
        bit done;
        br_pc = pc; br_target = tgt; br_type = ty; br_taken = tk;
        pred_en = pe; pred_taken = pt; pred_target = ptg; pred_index = pidx;
        flush = fl; br_valid = 1'b1;
        done = 0;
        for (int n = 0; n < 64 && !done; n++) begin
            tick();
            if (last_acc || fl) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL offer_timeout: br_ready stayed 0 for 64 cycles, expected acceptance");
        end
        br_valid = 1'b0;
        flush    = 1'b0;
    endtask

    // Monitor: compares every cycle, popping a queued command whenever one is presented.
    initial begin
        exp_cmd_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                check("operate_en", operate_en, exp_op_en);
                if (operate_en) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_cmd: got pc 0x%08h, expected no command", operate_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("cmd_flags", {add_entry, delete_entry, pre_error, pre_right,
                                            target_error, right_orien, push_ras, pop_ras}, e.flags);
                        check("operate_pc", operate_pc, e.pc);
                        check("operate_index", operate_index, e.idx);
                        check("right_target", right_target, e.tgt);
                    end
                end
                check("br_ready", br_ready, exp_q.size() < DEPTH);
                check("redirect_valid", redirect_valid, exp_redir_now);
                if (redirect_valid && exp_redir_now)
                    check("redirect_pc", redirect_pc, exp_redir_pc);
                check("branch_cnt", branch_cnt, exp_branch);
                check("mispred_cnt", mispred_cnt, exp_mis);
            end
        end
    end

    initial begin
        logic [31:0] pc, tgt;
        logic [2:0]  ty;
        logic        tk;
        int          guard;

        resetn = 1'b0; br_valid = 0; br_pc = 0; br_target = 0; br_type = 0; br_taken = 0;
        pred_en = 0; pred_taken = 0; pred_target = 0; pred_index = 0; flush = 0; update_stall = 0;
        #1;
        check("rst_br_ready", br_ready, 1);
        check("rst_operate_en", operate_en, 0);
        check("rst_redirect_valid", redirect_valid, 0);
        check("rst_operate_pc", operate_pc, 0);
        check("rst_right_target", right_target, 0);
        check("rst_branch_cnt", branch_cnt, 0);
        check("rst_mispred_cnt", mispred_cnt, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        resetn = 1'b1;
        mon_en = 1;

        // Direction mispredict on a hit: pre_error, fall-through redirect.
        offer(32'h1C00_0100, 32'h1C00_0200, 3'd1, 0, 1, 1, 32'h1C00_0200, 5'd7, 0);
        check("d36_operate_en", operate_en, 1);
        check("d36_pre_error", pre_error, 1);
        check("d36_right_orien", right_orien, 0);
        check("d36_index", operate_index, 7);
        check("d36_redirect_pc", redirect_pc, 32'h1C00_0104);
        check("d36_mispred_cnt", mispred_cnt, 1);
        idle(2);

        // Taken miss: add_entry one cycle later, redirect to target.
        offer(32'h1C00_0010, 32'h1C00_0040, 3'd1, 1, 0, 0, 32'h0, 5'd0, 0);
        check("d35_add_entry", add_entry, 1);
        check("d35_right_target", right_target, 32'h1C00_0040);
        check("d35_redirect_pc", redirect_pc, 32'h1C00_0040);
        idle(2);

        // CALL hit with correct target, then RET miss.
        offer(32'h1C00_0300, 32'h1C00_1000, 3'd3, 1, 1, 1, 32'h1C00_1000, 5'd3, 0);
        check("d37_call_pre_right", pre_right, 1);
        check("d37_call_push", push_ras, 1);
        check("d37_call_no_redirect", redirect_valid, 0);
        offer(32'h1C00_1010, 32'h1C00_0304, 3'd4, 1, 0, 0, 32'h0, 5'd0, 0);
        check("d37_ret_add", add_entry, 1);
        check("d37_ret_pop", pop_ras, 1);
        idle(2);

        // Stalled predictor: four fill the queue, the fifth waits for the release.
        update_stall = 1'b1;
        for (int i = 0; i < 4; i++)
            offer(32'h2000_0000 + 32'(i * 16), 32'h3000_0000 + 32'(i * 16), 3'd2, 1, 0, 1, 32'h0, 5'(i), 0);
        check("d38_full_br_ready", br_ready, 0);
        fork
            begin
                repeat (3) @(posedge clk);
                #3 update_stall = 1'b0;
            end
        join_none
        offer(32'h2000_0040, 32'h3000_0040, 3'd2, 1, 0, 1, 32'h0, 5'd4, 0);
        idle(6);

        // Fall-through past the top of the address space, then a flushed offer.
        offer(32'hFFFF_FFFC, 32'h1000_0000, 3'd1, 0, 1, 1, 32'h1000_0000, 5'd9, 0);
        check("d39_redirect_wrap", redirect_pc, 32'h0000_0000);
        offer(32'h1C00_0500, 32'h1C00_0600, 3'd1, 1, 0, 0, 32'h0, 5'd1, 1);
        check("d39_flush_no_redirect", redirect_valid, 0);
        idle(2);

        // Randomized traffic with random stalls and flushes.
        rand_stall = 1;
        for (int i = 0; i < 300; i++) begin
            idle($urandom_range(0, 2));
            ty  = 3'($urandom_range(0, 5));
            tk  = (ty == 3'd1) ? 1'($urandom_range(0, 1)) : (ty == 3'd0 ? 1'b0 : 1'b1);
            pc  = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
            tgt = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
            offer(pc, tgt, ty, tk, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 1) ? tgt : $urandom(), 5'($urandom_range(0, 31)),
                  $urandom_range(0, 7) == 0);
        end
        rand_stall = 0;
        update_stall = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            tick();
            guard++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        idle(2);

        // Reset while draining: everything pending is discarded.
        update_stall = 1'b1;
        for (int i = 0; i < 3; i++)
            offer(32'h4000_0000 + 32'(i * 8), 32'h5000_0000, 3'd2, 1, 0, 1, 32'h0, 5'd2, 0);
        update_stall = 1'b0;
        tick();
        mon_en = 0;
        resetn = 1'b0;
        #1;
        check("d40_operate_en", operate_en, 0);
        check("d40_br_ready", br_ready, 1);
        check("d40_branch_cnt", branch_cnt, 0);
        check("d40_mispred_cnt", mispred_cnt, 0);
        check("d40_operate_pc", operate_pc, 0);
        exp_q.delete();
        exp_branch = 0;
        exp_mis = 0;
        exp_op_en = 0;
        exp_redir_now = 0;
        idle(2);
        resetn = 1'b1;
        mon_en = 1;
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bpu_update_ctrl.md
BPU_UPDATE_CTRL -- requirements
Module: bpu_update_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4; update-command queue depth, power of two, at least 2.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 br_valid  in  1  resolved control-flow instruction offered this cycle.
REQ-005 br_ready  out  1  module accepts the offer; transfer occurs when br_valid && br_ready.
REQ-006 br_pc, br_target  in  32 each  instruction PC; actual target.
REQ-007 br_type  in  3  NONE=0, COND=1, JUMP=2, CALL=3, RET=4, IND=5.
REQ-008 br_taken  in  1  actual direction (always 1 for JUMP/CALL/RET/IND).
REQ-009 pred_en, pred_taken  in  1 each  fetch-time predictor hit and predicted direction.
REQ-010 pred_target  in  32; pred_index  in  5  predicted target and hit slot.
REQ-011 flush  in  1  when high, discard this cycle's offer (no enqueue, no redirect, no count).
REQ-012 update_stall  in  1  predictor cannot take a command this cycle.
REQ-013 operate_en  out  1  command valid; operate_pc out 32; operate_index out 5.
REQ-014 Command flags  out  1 each: add_entry, delete_entry, pre_error, pre_right, target_error, right_orien, push_ras, pop_ras.
REQ-015 right_target  out  32  actual target for the command.
REQ-016 redirect_valid  out  1; redirect_pc  out  32  fetch redirect on misprediction.
REQ-017 branch_cnt, mispred_cnt  out  32 each  performance counters.

Function
REQ-018 mispredict = pred_taken!=br_taken, OR (br_taken && pred_taken && pred_target!=br_target), OR (br_type==NONE && pred_en && pred_taken).
REQ-019 On an accepted, unflushed mispredict, redirect_valid SHALL pulse for exactly one cycle, the cycle after acceptance; redirect_pc = br_taken ? br_target : br_pc+4 (mod 2^32).
REQ-020 Command classification, first match wins: NONE&&pred_en -> delete_entry; !pred_en&&br_taken -> add_entry; pred_en&&br_taken&&pred_target!=br_target&&type!=RET -> target_error; pred_en -> pre_error if direction wrong, otherwise pre_right.
REQ-021 push_ras=1 for CALL, pop_ras=1 for RET, in addition to REQ-020 flags; right_orien=br_taken; right_target=br_target; operate_pc=br_pc; operate_index=pred_index.
REQ-022 Accepted offers yielding no flag, no push_ras and no pop_ras (NONE without a hit; COND not taken without a hit) SHALL NOT be enqueued.
REQ-023 Commands SHALL be enqueued in acceptance order, with one enqueue per cycle at most.
REQ-024 When the queue is non-empty and update_stall=0, the head SHALL appear on the operate_* outputs with operate_en=1 and dequeue that cycle; operate_* outputs are registered.
REQ-025 Enqueue-to-earliest-operate_en latency SHALL be 1 cycle; commands SHALL never be dropped or duplicated.
REQ-026 br_ready = !full; a simultaneous dequeue SHALL NOT raise br_ready in the same cycle.
REQ-027 When empty or stalled, operate_en=0; other operate_* outputs hold their previous values.
REQ-028 Simultaneous enqueue and dequeue on a non-empty queue SHALL keep occupancy unchanged; read and write pointers wrap modulo FIFO_DEPTH.
REQ-029 branch_cnt SHALL increment on accepted, unflushed offers with br_type!=NONE; mispred_cnt SHALL increment on each redirect; both saturate at 0xFFFF_FFFF.
REQ-030 flush SHALL NOT affect queued commands or counters already updated.

Reset
REQ-031 resetn low SHALL immediately empty the queue and clear operate_en, all command flags, redirect_valid, operate_pc, operate_index, right_target, redirect_pc and both counters to 0.
REQ-032 br_ready SHALL read 1 during and after reset; reset asserted mid-drain SHALL discard all pending commands.

Structure
REQ-033 A shared package SHALL hold the br_type encodings, the default FIFO_DEPTH and the command-record typedef (flags, pc, index, target).
REQ-034 The queue SHALL be a sub-module bpu_upd_fifo (synchronous FIFO, full/empty outputs).

Verification
REQ-035 COND at pc 0x1C000010, taken to 0x1C000040, pred_en=0 -> next cycle operate_en with add_entry=1, right_target=0x1C000040; redirect_pc=0x1C000040.
REQ-036 COND hit at index 7, pred_taken=1, br_taken=0 -> pre_error=1, right_orien=0, operate_index=7; redirect_pc=br_pc+4; mispred_cnt=1.
REQ-037 CALL hit, correct target -> pre_right=1, push_ras=1, no redirect; RET miss -> add_entry=1, pop_ras=1.
REQ-038 update_stall=1 while 5 taken misses are offered -> br_ready=0 after 4; release stall -> 5 commands emitted in order, one per cycle.
REQ-039 br_pc=0xFFFFFFFC mispredicted not-taken -> redirect_pc=0x00000000; offer with flush=1 -> no command, no redirect, counters unchanged.
REQ-040 resetn pulsed low with 3 queued commands -> operate_en=0 immediately; no stale command after release.
